// File: rtl/itcm_boot_loader_pkg.sv
// boot_loader_pkg: shared states and constants for the ITCM boot loader.
package boot_loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_e;
    typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam logic [31:0] ITCM_BASE     = 32'h0000_5000;
endpackage

// File: rtl/itcm_boot_loader_uart_rx.sv
// uart_rx_8n1: 8N1 UART receiver with glitch-rejecting start bit.
// Ports: clk, rst (sync, active high), rx_i (async serial line),
// byte_valid_o (1-cycle strobe), byte_data_o (received byte), frame_err_o (1-cycle, stop bit low).
module uart_rx_8n1
    import boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    rx_state_e st_q, st_d;
    logic s1_q, s2_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic valid_q, valid_d, ferr_q, ferr_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= RX_ARM;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            s1_q    <= rx_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
    // ARM waits for one full bit time of idle-high line before listening,
    // so a byte cut short by reset is never mistaken for a new start bit.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_ARM: begin
                if (!s2_q) cnt_d = '0;
                else if (cnt_q == FULL) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                end
            end
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !s2_q) st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    sh_d  = {s2_q, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    st_d    = RX_IDLE;
                    valid_d = s2_q;
                    ferr_d  = !s2_q;
                end
            end
            default: st_d = RX_ARM;
        endcase
    end
    assign byte_valid_o = valid_q;
    assign byte_data_o  = sh_q;
    assign frame_err_o  = ferr_q;
endmodule

// File: rtl/itcm_boot_loader.sv
// itcm_boot_loader: loads a framed UART image into the ITCM and holds the core until it verifies.
// Ports: clk, rst (sync, active high), uart_rx (serial in), itcm_we/itcm_addr/itcm_wdata (ITCM write),
// core_hold (core reset term), load_done (sticky success), load_error (sticky until next sync).
module itcm_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 1128,
    parameter int         MAX_WORDS    = 1024,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        itcm_we,
    output logic [11:0] itcm_addr,
    output logic [31:0] itcm_wdata,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error
);
    localparam int IW = $clog2(MAX_WORDS + 1);
    logic rx_valid, rx_ferr;
    logic [7:0] rx_data;
    state_e state_q, state_d;
    logic [15:0] len_q, len_d, len_new;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0] csum_q, csum_d;
    logic we_q, we_d, err_q, err_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, word;
    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (uart_rx),
        .byte_valid_o (rx_valid),
        .byte_data_o  (rx_data),
        .frame_err_o  (rx_ferr)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end
    // Bytes arrive little-endian, so each new byte enters at the top and the
    // first byte of the word ends up in bits [7:0] after the fourth.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        len_new = {rx_data, len_q[7:0]};
        word    = {rx_data, asm_q};
        if (rx_ferr && state_q != IDLE && state_q != DONE) begin
            state_d = ERROR;
            err_d   = 1'b1;
        end else if (state_q == DATA && we_q && 16'(idx_q) == len_q) begin
            // Leave DATA only after the last write strobe has been issued.
            state_d = CSUM;
        end else if (rx_valid) begin
            case (state_q)
                IDLE, ERROR: begin
                    state_d = IDLE;
                    if (rx_data == SYNC_BYTE) begin
                        state_d = LEN_LO;
                        err_d   = 1'b0;
                        idx_d   = '0;
                        bcnt_d  = '0;
                        csum_d  = '0;
                    end
                end
                LEN_LO: begin
                    len_d   = {8'h00, rx_data};
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    len_d   = len_new;
                    err_d   = len_new > 16'(MAX_WORDS);
                    state_d = err_d ? ERROR : (len_new == 16'd0 ? CSUM : DATA);
                end
                DATA: begin
                    asm_d  = word[31:8];
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = 12'({idx_q, 2'b00});
                        wdata_d = word;
                        idx_d   = idx_q + 1'b1;
                    end
                end
                CSUM: begin
                    state_d = rx_data == csum_q ? DONE : ERROR;
                    err_d   = rx_data != csum_q;
                end
                default: state_d = state_q;
            endcase
        end
    end
    assign itcm_we    = we_q;
    assign itcm_addr  = addr_q;
    assign itcm_wdata = wdata_q;
    assign load_done  = state_q == DONE;
    assign core_hold  = state_q != DONE;
    assign load_error = err_q;
endmodule

// File: tb/tb_itcm_boot_loader.sv
// tb_itcm_boot_loader: table-driven, directed and randomized checks of itcm_boot_loader.
module tb_itcm_boot_loader;
    localparam int CPB = 4;
    typedef struct {
        int         n;
        logic [7:0] b [12];
        int         nw;
        logic [31:0] w [2];
        logic       done;
        logic       err;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
    logic itcm_we, core_hold, load_done, load_error;
    logic [11:0] itcm_addr;
    logic [31:0] itcm_wdata;
    int n_vec = 0, n_bad = 0;
    logic [43:0] wq [$];
    logic [7:0] tx_q [$];
    logic [31:0] exp_w [$];
    logic we_prev = 1'b0;
    vec_t tbl [7];
    logic [7:0] b, cs;
    logic [31:0] w;
    int len, good;

    always #5 clk = ~clk;

    itcm_boot_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(1024), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .itcm_we    (itcm_we),
        .itcm_addr  (itcm_addr),
        .itcm_wdata (itcm_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always @(negedge clk) begin
        if (itcm_we) begin
            wq.push_back({itcm_addr, itcm_wdata});
            n_vec++;
            if (we_prev) begin
                n_bad++;
                $display("FAIL we_single_cycle: got 2 consecutive strobes, expected 1");
            end
        end
        we_prev = itcm_we;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [43:0] act, input logic [43:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit bad_stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(!bad_stop);
        if (bad_stop) bit_time(1'b1);
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        wq.delete();
    endtask

    task automatic load_vec(input int v);
        tx_q.delete();
        exp_w.delete();
        for (int j = 0; j < tbl[v].n; j++) tx_q.push_back(tbl[v].b[j]);
        for (int j = 0; j < tbl[v].nw; j++) exp_w.push_back(tbl[v].w[j]);
    endtask

    task automatic check_result(input string nm, input logic done, input logic err);
        chk({nm, " write_count"}, 44'(wq.size()), 44'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
            chk({nm, " write"}, wq[i], {12'(i * 4), exp_w[i]});
        chk({nm, " load_done"}, 44'(load_done), 44'(done));
        chk({nm, " load_error"}, 44'(load_error), 44'(err));
        chk({nm, " core_hold"}, 44'(core_hold), 44'(!done));
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, " itcm_we"}, 44'(itcm_we), 44'(0));
        chk({nm, " itcm_addr"}, 44'(itcm_addr), 44'(0));
        chk({nm, " itcm_wdata"}, 44'(itcm_wdata), 44'(0));
        chk({nm, " core_hold"}, 44'(core_hold), 44'(1));
        chk({nm, " load_done"}, 44'(load_done), 44'(0));
        chk({nm, " load_error"}, 44'(load_error), 44'(0));
    endtask

    initial begin
        tbl[0] = '{12, '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C},
                   2, '{32'h0000_0013, 32'h0000_006F}, 1'b1, 1'b0};
        tbl[1] = '{12, '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D},
                   2, '{32'h0000_0013, 32'h0000_006F}, 1'b0, 1'b1};
        tbl[2] = '{3, '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   0, '{32'h0, 32'h0}, 1'b0, 1'b1};
        tbl[3] = '{7, '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   0, '{32'h0, 32'h0}, 1'b1, 1'b0};
        tbl[4] = '{4, '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   0, '{32'h0, 32'h0}, 1'b0, 1'b1};
        tbl[5] = '{8, '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   1, '{32'hA5A5_A5A5, 32'h0}, 1'b1, 1'b0};
        tbl[6] = '{3, '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   0, '{32'h0, 32'h0}, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check_reset_vals("reset");

        for (int v = 0; v < 7; v++) begin
            do_reset();
            load_vec(v);
            send_q();
            check_result($sformatf("vec%0d", v), tbl[v].done, tbl[v].err);
        end

        do_reset();
        load_vec(1);
        send_q();
        check_result("badcsum", 1'b0, 1'b1);
        wq.delete();
        load_vec(0);
        send_q();
        check_result("resend", 1'b1, 1'b0);

        do_reset();
        exp_w.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (8) @(negedge clk);
        check_result("frame_err", 1'b0, 1'b1);

        do_reset();
        exp_w.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (8) @(negedge clk);
        check_result("glitch", 1'b1, 1'b0);

        do_reset();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00};
        send_q();
        chk("midword writes", 44'(wq.size()), 44'(1));
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midword_rst");
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        wq.delete();
        load_vec(0);
        send_q();
        check_result("after_rst", 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            do_reset();
            tx_q.delete();
            exp_w.delete();
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                do b = 8'($urandom); while (b == 8'hA5);
                tx_q.push_back(b);
            end
            len = $urandom_range(1, 5);
            tx_q.push_back(8'hA5);
            tx_q.push_back(8'(len));
            tx_q.push_back(8'h00);
            cs = 8'h00;
            for (int k = 0; k < len; k++) begin
                w = $urandom;
                exp_w.push_back(w);
                for (int j = 0; j < 4; j++) begin
                    tx_q.push_back(w[8*j +: 8]);
                    cs = cs ^ w[8*j +: 8];
                end
            end
            good = $urandom_range(0, 1);
            tx_q.push_back(good != 0 ? cs : cs ^ 8'h5A);
            send_q();
            check_result($sformatf("rand%0d", r), good != 0, good == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/itcm_boot_loader.md
# itcm_boot_loader

Serial boot loader placed in front of the RV32E core. It receives a framed program image over a UART receive line and writes it word-by-word into the instruction TCM. While loading, it holds the core in reset. It releases the core only after the frame checksum verifies, so that fetch begins at address 0 with a complete image.

## Interface

Parameters:
- CLKS_PER_BIT, 1128, clk cycles per UART bit (130 MHz / 115200); minimum 4.
- MAX_WORDS, 1024, ITCM capacity in 32-bit words (4 KiB).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idle high; 8N1, LSB first.
- itcm_we  out  1  one-cycle ITCM write strobe.
- itcm_addr  out  12  ITCM byte address, always word aligned ([1:0]=0).
- itcm_wdata  out  32  word to write.
- core_hold  out  1  high = keep core in reset; drives the core's reset OR-term.
- load_done  out  1  sticky; image loaded and verified.
- load_error  out  1  sticky until the next accepted SYNC_BYTE.

## Operation

- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words of 4 bytes each in little-endian order, then CSUM.
  - LEN is a 16-bit word count.
  - CSUM is the XOR of every payload byte. For LEN=0, CSUM=8'h00.
- Reset values: itcm_we=0, itcm_addr=0, itcm_wdata=0, core_hold=1, load_done=0, load_error=0, FSM=IDLE.
- uart_rx handling:
  - Passes through a 2-flop synchronizer.
  - A start bit is a falling edge of the synchronized line.
  - The start bit is re-sampled at CLKS_PER_BIT/2. If it reads high there, it is discarded as a glitch.
  - Data bits are sampled at mid-bit.
  - A stop bit sampled low raises frame_err for one cycle. No byte_valid is produced for that byte.
- FSM states:
  - IDLE: byte==SYNC_BYTE → LEN_LO and clear load_error. Any other byte is ignored.
  - LEN_LO: latch low byte → LEN_HI.
  - LEN_HI: latch high byte.
    - LEN>MAX_WORDS → ERROR.
    - LEN==0 → CSUM.
    - Otherwise → DATA.
  - DATA: shift bytes into a word assembly register and XOR each byte into the checksum accumulator.
    - On the 4th byte, pulse itcm_we with itcm_addr = word_idx*4, then increment word_idx.
    - After word LEN-1 is written → CSUM.
  - CSUM: byte==accumulator → DONE, else → ERROR.
  - DONE: load_done=1 and core_hold=0. All further bytes are ignored until rst.
  - ERROR: load_error=1 and core_hold stays 1. Return to IDLE on the next byte_valid, which is itself evaluated as an IDLE byte.
- A frame_err in any state other than IDLE or DONE → ERROR. In IDLE it is ignored.
- Words already written before an ERROR remain in ITCM. A retransmitted frame overwrites them from address 0.
- Re-sync: SYNC_BYTE appearing inside a payload is data, not a restart.

## Timing

- byte_valid asserts 1 clk after the stop-bit mid-sample.
- itcm_we asserts the cycle after the byte_valid of byte 4. itcm_addr and itcm_wdata are valid and stable in that same cycle.
- itcm_we is never high for more than 1 consecutive cycle and is never high outside DATA.
- core_hold falls on the cycle after the CSUM byte_valid, in the same edge that sets load_done.
- Reset during a load: all state returns to reset values on the next clk edge. A partially received UART byte is discarded; the receiver re-arms only after the line has been idle high for one full bit time.
- Back-to-back frames with a minimum stop-bit gap must be received without loss.

## Structure

- Package boot_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR);
  - the SYNC_BYTE default;
  - the ITCM base constant (32'h5000, shared with the core's ITCM store decode).
- One sub-module, uart_rx_8n1.
  - Contains the synchronizer, bit counter, baud counter and shift register.
  - Outputs: byte_valid, byte_data[7:0], frame_err.
- The top level contains the FSM, word assembly, word_idx counter and checksum.

## Test plan

Benches run with CLKS_PER_BIT=4.
- Basic load: send A5 02 00 | 13 00 00 00 | 6F 00 00 00 | CSUM=7C.
  - Expect itcm_we at addr 0x000 with 32'h00000013, then at addr 0x004 with 32'h0000006F.
  - Then load_done=1 and core_hold=0.
- Bad checksum: same frame with CSUM=7D.
  - Expect 2 writes, then load_error=1, core_hold=1, load_done=0.
  - Resend the correct frame → load_done=1 and load_error=0.
- Length overflow: A5 01 04, i.e. LEN=1025.
  - Expect ERROR immediately after LEN_HI, no itcm_we, load_error=1.
- Zero-length frame and noise:
  - Noise bytes 00 FF 12 before A5 00 00 00 → no writes, load_done=1.
  - A 1-cycle low glitch on uart_rx produces no byte.
- Framing error and reset:
  - Stop bit forced low on the 3rd data byte → ERROR, load_error=1.
  - Separately, asserting rst mid-word → all outputs return to reset values, and a fresh full frame loads correctly from addr 0.
